// File: rtl/klotski_mover_pkg.sv
// Shared types and helpers for the Klotski gantry block mover.
package klotski_mover_pkg;

    localparam int BOARD_DIM = 4;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MOVE_X  = 3'd1,
        MOVE_Y  = 3'd2,
        GRAB    = 3'd3,
        PUSH    = 3'd4,
        RELEASE = 3'd5,
        DONE    = 3'd6
    } state_t;

    // A push is illegal when the block would leave the board.
    function automatic logic move_illegal(input logic [1:0] row, input logic [1:0] col,
                                          input dir_t dir);
        case (dir)
            UP:      return row == 2'd0;
            DOWN:    return row == 2'(BOARD_DIM - 1);
            LEFT:    return col == 2'd0;
            RIGHT:   return col == 2'(BOARD_DIM - 1);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] abs_diff(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/klotski_block_mover_step_pulse_gen.sv
// Burst generator: step_count square-wave periods of 2*STEP_HALF cycles, high half first.
module step_pulse_gen #(
    parameter int STEP_HALF = 2500
) (
    input  logic        i_Clk,
    input  logic        i_rst_n,
    input  logic        start,
    input  logic [15:0] step_count,
    output logic        step,
    output logic        done
);
    localparam int PW = (2 * STEP_HALF > 1) ? $clog2(2 * STEP_HALF) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(2 * STEP_HALF - 1);
    localparam logic [PW-1:0] HIGH_LAST  = PW'(STEP_HALF - 1);

    logic          active_reg;
    logic          step_reg;
    logic [PW-1:0] phase_reg;
    logic [15:0]   steps_left_reg;

    // A start on the same edge as the final cycle of a burst reloads without a gap.
    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active_reg     <= 1'b0;
            step_reg       <= 1'b0;
            phase_reg      <= '0;
            steps_left_reg <= '0;
        end else if (start) begin
            active_reg     <= (step_count != 16'd0);
            step_reg       <= (step_count != 16'd0);
            phase_reg      <= '0;
            steps_left_reg <= step_count;
        end else if (active_reg) begin
            if (phase_reg == PHASE_LAST) begin
                phase_reg <= '0;
                if (steps_left_reg == 16'd1) begin
                    active_reg <= 1'b0;
                    step_reg   <= 1'b0;
                end else begin
                    steps_left_reg <= steps_left_reg - 16'd1;
                    step_reg       <= 1'b1;
                end
            end else begin
                phase_reg <= phase_reg + 1'b1;
                step_reg  <= (phase_reg < HIGH_LAST);
            end
        end
    end

    assign step = step_reg;
    // High during the last cycle of the burst so the caller can chain states seamlessly.
    assign done = active_reg && (phase_reg == PHASE_LAST) && (steps_left_reg == 16'd1);

endmodule

// File: rtl/klotski_block_mover.sv
// Moves the gantry head to a source cell, magnetically pushes one cell, then reports done.
module klotski_block_mover
    import klotski_mover_pkg::*;
#(
    parameter int STEPS_PER_CELL = 200,
    parameter int STEP_HALF      = 2500,
    parameter int SETTLE         = 500000
) (
    input  logic       i_Clk,
    input  logic       i_rst_n,
    input  logic       i_bm_en,
    input  logic [1:0] i_src_row,
    input  logic [1:0] i_src_col,
    input  logic [1:0] i_dir,
    output logic       o_step_x,
    output logic       o_dir_x,
    output logic       o_step_y,
    output logic       o_dir_y,
    output logic       o_magnet,
    output logic       o_bm_done,
    output logic       o_err,
    output logic       o_busy,
    output logic [2:0] o_state
);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [15:0]   CELL_STEPS  = 16'(STEPS_PER_CELL);

    state_t        state_reg, state_next;
    logic [1:0]    head_row_reg, head_col_reg;
    logic [1:0]    src_row_reg, src_col_reg;
    dir_t          dir_reg;
    logic [SW-1:0] settle_cnt_reg;
    logic          sel_x_reg, sel_y_reg;
    logic          dir_x_reg, dir_y_reg;
    logic          magnet_reg, done_reg, err_reg, busy_reg;

    logic [1:0]    req_row, req_col;
    dir_t          req_dir;
    logic          push_on_x;
    logic [1:0]    dest_row, dest_col;
    logic          gen_start, gen_step, gen_done;
    logic [15:0]   gen_count;

    // In IDLE the request still sits on the inputs; afterwards it lives in the latches.
    always_comb begin
        req_row   = (state_reg == IDLE) ? i_src_row : src_row_reg;
        req_col   = (state_reg == IDLE) ? i_src_col : src_col_reg;
        req_dir   = (state_reg == IDLE) ? dir_t'(i_dir) : dir_reg;
        push_on_x = (req_dir == LEFT) || (req_dir == RIGHT);
    end

    always_comb begin
        dest_row = src_row_reg;
        dest_col = src_col_reg;
        case (dir_reg)
            UP:      dest_row = src_row_reg - 2'd1;
            DOWN:    dest_row = src_row_reg + 2'd1;
            LEFT:    dest_col = src_col_reg - 2'd1;
            RIGHT:   dest_col = src_col_reg + 2'd1;
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (i_bm_en) begin
                    if (move_illegal(req_row, req_col, req_dir))
                        state_next = DONE;
                    else if (req_col != head_col_reg)
                        state_next = MOVE_X;
                    else if (req_row != head_row_reg)
                        state_next = MOVE_Y;
                    else
                        state_next = GRAB;
                end
            end
            MOVE_X:  if (gen_done) state_next = (src_row_reg != head_row_reg) ? MOVE_Y : GRAB;
            MOVE_Y:  if (gen_done) state_next = GRAB;
            GRAB:    if (settle_cnt_reg == SETTLE_LAST) state_next = PUSH;
            PUSH:    if (gen_done) state_next = RELEASE;
            RELEASE: if (settle_cnt_reg == SETTLE_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gen_start = (state_next != state_reg) && (state_next inside {MOVE_X, MOVE_Y, PUSH});
        case (state_next)
            MOVE_X:  gen_count = 16'(abs_diff(req_col, head_col_reg)) * CELL_STEPS;
            MOVE_Y:  gen_count = 16'(abs_diff(req_row, head_row_reg)) * CELL_STEPS;
            default: gen_count = CELL_STEPS;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= IDLE;
            head_row_reg   <= '0;
            head_col_reg   <= '0;
            src_row_reg    <= '0;
            src_col_reg    <= '0;
            dir_reg        <= UP;
            settle_cnt_reg <= '0;
            sel_x_reg      <= 1'b0;
            sel_y_reg      <= 1'b0;
            dir_x_reg      <= 1'b0;
            dir_y_reg      <= 1'b0;
            magnet_reg     <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && i_bm_en) begin
                src_row_reg <= i_src_row;
                src_col_reg <= i_src_col;
                dir_reg     <= dir_t'(i_dir);
            end
            settle_cnt_reg <= (state_next != state_reg) ? '0 : settle_cnt_reg + 1'b1;

            // Direction changes only on entry to a motion state, where step was low the cycle before.
            if (gen_start) begin
                sel_x_reg <= (state_next == MOVE_X) || (state_next == PUSH && push_on_x);
                sel_y_reg <= (state_next == MOVE_Y) || (state_next == PUSH && !push_on_x);
                case (state_next)
                    MOVE_X:  dir_x_reg <= (req_col > head_col_reg);
                    MOVE_Y:  dir_y_reg <= (req_row > head_row_reg);
                    PUSH: begin
                        if (push_on_x) dir_x_reg <= (req_dir == RIGHT);
                        else           dir_y_reg <= (req_dir == DOWN);
                    end
                    default: ;
                endcase
            end else if (gen_done) begin
                sel_x_reg <= 1'b0;
                sel_y_reg <= 1'b0;
            end

            magnet_reg <= (state_next == GRAB) || (state_next == PUSH);
            busy_reg   <= (state_next != IDLE);
            done_reg   <= (state_next == DONE);
            err_reg    <= (state_reg == IDLE) && (state_next == DONE);
            if (state_reg == RELEASE && state_next == DONE) begin
                head_row_reg <= dest_row;
                head_col_reg <= dest_col;
            end
        end
    end

    step_pulse_gen #(
        .STEP_HALF (STEP_HALF)
    ) u_step_gen (
        .i_Clk      (i_Clk),
        .i_rst_n    (i_rst_n),
        .start      (gen_start),
        .step_count (gen_count),
        .step       (gen_step),
        .done       (gen_done)
    );

    assign o_step_x  = gen_step & sel_x_reg;
    assign o_step_y  = gen_step & sel_y_reg;
    assign o_dir_x   = dir_x_reg;
    assign o_dir_y   = dir_y_reg;
    assign o_magnet  = magnet_reg;
    assign o_bm_done = done_reg;
    assign o_err     = err_reg;
    assign o_busy    = busy_reg;
    assign o_state   = state_reg;

endmodule

// File: tb/tb_klotski_block_mover.sv
// Randomized move sequences compared cycle by cycle against a board-level reference model.
module tb_klotski_block_mover;
    localparam int SPC = 4;
    localparam int SH  = 2;
    localparam int ST  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bm_en = 1'b0;
    logic [1:0] src_row = 2'd0, src_col = 2'd0, dir = 2'd0;
    logic       step_x, dir_x, step_y, dir_y, magnet, bm_done, err, busy;
    logic [2:0] state;

    always #5 clk = ~clk;

    klotski_block_mover #(
        .STEPS_PER_CELL (SPC),
        .STEP_HALF      (SH),
        .SETTLE         (ST)
    ) dut (
        .i_Clk     (clk),
        .i_rst_n   (rst_n),
        .i_bm_en   (bm_en),
        .i_src_row (src_row),
        .i_src_col (src_col),
        .i_dir     (dir),
        .o_step_x  (step_x),
        .o_dir_x   (dir_x),
        .o_step_y  (step_y),
        .o_dir_y   (dir_y),
        .o_magnet  (magnet),
        .o_bm_done (bm_done),
        .o_err     (err),
        .o_busy    (busy),
        .o_state   (state)
    );

    typedef struct packed {
        logic [2:0] st;
        logic busy, mag, sx, sy, dx, dy, done, err;
    } cyc_t;

    cyc_t exp_q[$];
    int   check_cnt = 0;
    int   error_cnt = 0;
    int   m_row = 0, m_col = 0;
    bit   m_dx = 1'b0, m_dy = 1'b0;
    logic prev_sx = 1'b0, prev_sy = 1'b0, prev_dx = 1'b0, prev_dy = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        check_cnt++;
        if (got !== expv) begin
            error_cnt++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    function automatic cyc_t mk(input int st, input bit mag, input bit sx, input bit sy,
                                input bit done, input bit e);
        cyc_t c;
        c.st = 3'(st); c.busy = (st != 0); c.mag = mag; c.sx = sx; c.sy = sy;
        c.dx = m_dx; c.dy = m_dy; c.done = done; c.err = e;
        return c;
    endfunction

    task automatic add_motion(input int st, input int steps, input bit on_x);
        for (int i = 0; i < steps * 2 * SH; i++) begin
            bit s = ((i % (2 * SH)) < SH);
            exp_q.push_back(mk(st, st == 4, on_x && s, !on_x && s, 1'b0, 1'b0));
        end
    endtask

    // Expected per-cycle trace of one request, starting at the cycle the request is taken.
    task automatic build_expect(input int r, input int c, input int d);
        bit illegal = (d == 0 && r == 0) || (d == 1 && r == 3) || (d == 2 && c == 0) || (d == 3 && c == 3);
        if (illegal) begin
            exp_q.push_back(mk(6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
            return;
        end
        if (c != m_col) begin
            m_dx = (c > m_col);
            add_motion(1, SPC * ((c > m_col) ? c - m_col : m_col - c), 1'b1);
        end
        if (r != m_row) begin
            m_dy = (r > m_row);
            add_motion(2, SPC * ((r > m_row) ? r - m_row : m_row - r), 1'b0);
        end
        repeat (ST) exp_q.push_back(mk(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        if (d >= 2) m_dx = (d == 3);
        else        m_dy = (d == 1);
        add_motion(4, SPC, d >= 2);
        repeat (ST) exp_q.push_back(mk(5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        m_row = r + int'(d == 1) - int'(d == 0);
        m_col = c + int'(d == 3) - int'(d == 2);
    endtask

    task automatic compare_cycle(input string tag, input cyc_t e);
        cyc_t o;
        logic viol;
        o = {state, busy, magnet, step_x, step_y, dir_x, dir_y, bm_done, err};
        check_eq(tag, 32'(o), 32'(e));
        viol = ((o.dx != prev_dx) && prev_sx) || ((o.dy != prev_dy) && prev_sy) || (o.sx && o.sy);
        check_eq({tag, "_axis"}, 32'(viol), 32'd0);
        prev_sx = o.sx; prev_sy = o.sy; prev_dx = o.dx; prev_dy = o.dy;
    endtask

    task automatic run_move(input string name, input int r, input int c, input int d,
                            input bit poke, output int done_at, output int n_done);
        cyc_t e;
        int   idx, pushi;
        build_expect(r, c, d);
        @(negedge clk);
        src_row = 2'(r); src_col = 2'(c); dir = 2'(d); bm_en = 1'b1;
        @(negedge clk);
        bm_en = 1'b0;
        idx = 0; pushi = 0; done_at = -1; n_done = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare_cycle($sformatf("%s_c%0d", name, idx), e);
            if (bm_done) begin
                n_done++;
                if (done_at < 0) done_at = idx;
            end
            if (poke && ((e.st == 3'd4 && pushi == 5) || e.st == 3'd6)) begin
                bm_en = 1'b1;
                src_row = 2'($urandom_range(3, 0));
                src_col = 2'($urandom_range(3, 0));
                dir = 2'($urandom_range(3, 0));
            end
            if (e.st == 3'd4) pushi++;
            idx++;
            @(negedge clk);
            bm_en = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            compare_cycle($sformatf("%s_idle%0d", name, i), mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            if (bm_done) n_done++;
            if (i == 0) @(negedge clk);
        end
        $display("move %s src=(%0d,%0d) dir=%0d poke=%0d cycles=%0d done_at=%0d head=(%0d,%0d)",
                 name, r, c, d, poke, idx, done_at, m_row, m_col);
    endtask

    task automatic reset_mid_push();
        cyc_t e;
        int   pushi;
        bit   hit;
        build_expect(1, 2, 2);
        @(negedge clk);
        src_row = 2'd1; src_col = 2'd2; dir = 2'd2; bm_en = 1'b1;
        @(negedge clk);
        bm_en = 1'b0;
        pushi = 0; hit = 1'b0;
        while (exp_q.size() > 0 && !hit) begin
            e = exp_q.pop_front();
            compare_cycle($sformatf("rst_mv_c%0d", pushi), e);
            if (e.st == 3'd4) begin
                if (pushi == 5) begin
                    #1 rst_n = 1'b0;
                    #1;
                    check_eq("rst_async_outputs",
                             32'({state, busy, magnet, step_x, step_y, dir_x, dir_y, bm_done, err}), 32'd0);
                    hit = 1'b1;
                end
                pushi++;
            end
            if (!hit) @(negedge clk);
        end
        check_eq("rst_reached_push", 32'(hit), 32'd1);
        exp_q.delete();
        m_row = 0; m_col = 0; m_dx = 1'b0; m_dy = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_held_outputs",
                 32'({state, busy, magnet, step_x, step_y, dir_x, dir_y, bm_done, err}), 32'd0);
        prev_sx = 1'b0; prev_sy = 1'b0; prev_dx = 1'b0; prev_dy = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        compare_cycle("rst_release_idle", mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        $display("move rst_mid_push src=(1,2) dir=2 aborted in PUSH head=(0,0)");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_at, n_done, r, c, d;
        bit poke;
        repeat (2) @(negedge clk);
        compare_cycle("reset_state", mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b1;

        run_move("t1_right", 0, 0, 3, 1'b0, done_at, n_done);
        check_eq("t1_done_at", 32'(done_at), 32'd22);
        run_move("t2_down", 2, 3, 1, 1'b0, done_at, n_done);
        check_eq("t2_done_at", 32'(done_at), 32'd86);
        run_move("t3_illegal", 0, 2, 0, 1'b0, done_at, n_done);
        check_eq("t3_done_at", 32'(done_at), 32'd0);
        run_move("t4_poke", 1, 1, 3, 1'b1, done_at, n_done);
        check_eq("t4_one_done", 32'(n_done), 32'd1);

        reset_mid_push();
        run_move("t6_after_rst", 1, 1, 3, 1'b0, done_at, n_done);
        check_eq("t6_done_at", 32'(done_at), 32'd54);

        for (int i = 0; i < 20; i++) begin
            r = int'($urandom_range(3, 0));
            c = int'($urandom_range(3, 0));
            d = int'($urandom_range(3, 0));
            poke = 1'($urandom_range(1, 0));
            run_move($sformatf("rnd%0d", i), r, c, d, poke, done_at, n_done);
            check_eq($sformatf("rnd%0d_one_done", i), 32'(n_done), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
